// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage encodings and constants
package mips_pkg;

  // Fetch FSM state encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_RST   = 2'd0;
  localparam fetch_state_t S_FETCH = 2'd1;
  localparam fetch_state_t S_EXEC  = 2'd2;

  // Byte distance between consecutive instruction words
  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory req/ack bus
interface instr_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  // Fetch stage drives the request, memory answers with ack/rdata
  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC priority mux and target adders
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] imm_ext_i,
  input  logic [25:0] jump_idx_i,
  input  logic [31:0] jr_addr_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        jr_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic        unused_imm_hi;

  // Offset is in words; the top two bits fall off the shift, sum wraps mod 2^32
  assign branch_tgt    = pc_plus4_i + {imm_ext_i[29:0], 2'b00};
  assign jump_tgt      = {pc_plus4_i[31:28], jump_idx_i, 2'b00};
  assign jr_tgt        = {jr_addr_i[31:2], 2'b00};
  assign unused_imm_hi = ^imm_ext_i[31:30];

  // Only the winning redirect can report misalignment, and only jr can misalign
  assign misalign_o = jr_i & (|jr_addr_i[1:0]);

  // Priority: jr > jump > branch > sequential
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jr_i) begin
      next_pc_o = jr_tgt;
    end else if (jump_i) begin
      next_pc_o = jump_tgt;
    end else if (branch_i) begin
      next_pc_o = branch_tgt;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and multi-cycle instruction fetch FSM
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 branch_i,
  input  logic [31:0]          imm_ext_i,
  input  logic                 jump_i,
  input  logic [25:0]          jump_idx_i,
  input  logic                 jr_i,
  input  logic [31:0]          jr_addr_i,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          pc_plus4_o,
  output logic                 instr_valid_o,
  output logic                 fault_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc4_q, pc4_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;
  logic         misalign;
  logic         redirect_cycle;

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i (pc4_q),
    .imm_ext_i  (imm_ext_i),
    .jump_idx_i (jump_idx_i),
    .jr_addr_i  (jr_addr_i),
    .branch_i   (branch_i),
    .jump_i     (jump_i),
    .jr_i       (jr_i),
    .next_pc_o  (next_pc),
    .misalign_o (misalign)
  );

  // Redirect inputs are only meaningful when decode accepts the instruction
  assign redirect_cycle = (state_q == S_EXEC) && !stall_i;

  // Next-state logic: wait for ack in FETCH, hold in EXEC until not stalled
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall_i) begin
          pc_d    = next_pc;
          pc4_d   = next_pc + PC_INCR;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + PC_INCR;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Request stays asserted with a stable address for the whole FETCH wait
  assign imem.req      = (state_q == S_FETCH);
  assign imem.addr     = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc4_q;
  assign instr_valid_o = valid_q;
  assign fault_o       = redirect_cycle && misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] imm_ext_i;
  logic        jump_i;
  logic [25:0] jump_idx_i;
  logic        jr_i;
  logic [31:0] jr_addr_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        fault_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t sb_q[$];
  int  vec_cnt = 0;
  int  err_cnt = 0;

  instr_fetch_if imem_if ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .imm_ext_i     (imm_ext_i),
    .jump_i        (jump_i),
    .jump_idx_i    (jump_idx_i),
    .jr_i          (jr_i),
    .jr_addr_i     (jr_addr_i),
    .imem          (imem_if),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_valid_o (instr_valid_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_redirects();
    stall_i    = 1'b0;
    branch_i   = 1'b0;
    imm_ext_i  = 32'h0;
    jump_i     = 1'b0;
    jump_idx_i = 26'h0;
    jr_i       = 1'b0;
    jr_addr_i  = 32'h0;
  endtask

  // Called at a negedge; serves one fetch at exp_addr after wt wait cycles
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data, input int wt);
    logic [31:0] exp_pc4;
    sb_t         got;
    for (int i = 0; i < 20 && !imem_if.req; i++) @(negedge clk_i);
    check_vec("req_seen", {31'h0, imem_if.req}, 32'h1);
    check_vec("fetch_addr", imem_if.addr, exp_addr);
    for (int w = 0; w < wt; w++) begin
      check_vec("wait_valid", {31'h0, instr_valid_o}, 32'h0);
      @(negedge clk_i);
      check_vec("wait_req", {31'h0, imem_if.req}, 32'h1);
      check_vec("wait_addr", imem_if.addr, exp_addr);
    end
    imem_if.ack   = 1'b1;
    imem_if.rdata = data;
    sb_q.push_back('{pc: exp_addr, instr: data});
    @(negedge clk_i);
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'h0;
    check_vec("valid_rise", {31'h0, instr_valid_o}, 32'h1);
    check_vec("exec_req", {31'h0, imem_if.req}, 32'h0);
    if (instr_valid_o && sb_q.size() > 0) begin
      got     = sb_q.pop_front();
      exp_pc4 = got.pc + 32'd4;
      check_vec("instr", instr_o, got.instr);
      check_vec("pc", pc_o, got.pc);
      check_vec("pc_plus4", pc_plus4_o, exp_pc4);
    end
  endtask

  // Called at a negedge in EXEC; applies one redirect cycle
  task automatic exec_step(input logic br, input logic [31:0] imm, input logic jmp,
                           input logic [25:0] idx, input logic jr, input logic [31:0] jra,
                           input logic exp_fault);
    stall_i    = 1'b0;
    branch_i   = br;
    imm_ext_i  = imm;
    jump_i     = jmp;
    jump_idx_i = idx;
    jr_i       = jr;
    jr_addr_i  = jra;
    #1;
    check_vec("fault", {31'h0, fault_o}, {31'h0, exp_fault});
    @(negedge clk_i);
    clear_redirects();
    #1;
    check_vec("fault_clear", {31'h0, fault_o}, 32'h0);
    check_vec("valid_fall", {31'h0, instr_valid_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_redirects();
    rst_i         = 1'b1;
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'h0;
    repeat (2) @(negedge clk_i);
    check_vec("rst_pc", pc_o, 32'h0);
    check_vec("rst_pc4", pc_plus4_o, 32'h4);
    check_vec("rst_instr", instr_o, 32'h0);
    check_vec("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    check_vec("rst_req", {31'h0, imem_if.req}, 32'h0);
    check_vec("rst_addr", imem_if.addr, 32'h0);
    check_vec("rst_fault", {31'h0, fault_o}, 32'h0);
    rst_i = 1'b0;
    #1;
    check_vec("first_cycle_req", {31'h0, imem_if.req}, 32'h0);
    @(negedge clk_i);
    check_vec("second_cycle_req", {31'h0, imem_if.req}, 32'h1);

    fetch_one(32'h0000_0000, 32'h2008_0005, 0);
    exec_step(0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
    fetch_one(32'h0000_0004, 32'h8C09_0000, 3);
    exec_step(0, 32'h0, 1, 26'h40, 0, 32'h0, 0);
    fetch_one(32'h0000_0100, 32'h1000_FFFE, 0);
    exec_step(1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0, 0);
    fetch_one(32'h0000_00FC, 32'h0000_0020, 1);
    exec_step(0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
    fetch_one(32'h0000_0100, 32'h1000_0003, 0);
    exec_step(1, 32'h0000_0003, 0, 26'h0, 0, 32'h0, 0);
    fetch_one(32'h0000_0110, 32'h0100_0008, 0);
    exec_step(0, 32'h0, 0, 26'h0, 1, 32'h1000_0000, 0);
    fetch_one(32'h1000_0000, 32'h0800_0040, 2);
    exec_step(1, 32'h0000_0007, 1, 26'h40, 0, 32'h0, 0);
    fetch_one(32'h1000_0100, 32'h0040_0008, 0);
    exec_step(1, 32'h0000_0007, 1, 26'h40, 1, 32'h0000_0203, 1);
    fetch_one(32'h0000_0200, 32'h1234_5678, 0);

    for (int i = 0; i < 4; i++) begin
      stall_i       = 1'b1;
      branch_i      = i[0];
      imm_ext_i     = 32'h0000_0010;
      jr_i          = (i == 2);
      jr_addr_i     = 32'h0000_0003;
      imem_if.ack   = 1'b1;
      imem_if.rdata = 32'hBAD0_BAD0;
      #1;
      check_vec("stall_fault", {31'h0, fault_o}, 32'h0);
      @(negedge clk_i);
      check_vec("stall_valid", {31'h0, instr_valid_o}, 32'h1);
      check_vec("stall_req", {31'h0, imem_if.req}, 32'h0);
      check_vec("stall_instr", instr_o, 32'h1234_5678);
      check_vec("stall_pc", pc_o, 32'h0000_0200);
    end
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'h0;
    exec_step(1, 32'h0000_0001, 0, 26'h0, 0, 32'h0, 0);
    fetch_one(32'h0000_0208, 32'h0000_0008, 0);
    exec_step(0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0);
    fetch_one(32'hFFFF_FFFC, 32'hAAAA_5555, 0);
    exec_step(0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
    fetch_one(32'h0000_0000, 32'h5555_AAAA, 0);
    exec_step(0, 32'h0, 0, 26'h0, 0, 32'h0, 0);

    check_vec("mid_req", {31'h0, imem_if.req}, 32'h1);
    check_vec("mid_addr", imem_if.addr, 32'h0000_0004);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_vec("mid_rst_req", {31'h0, imem_if.req}, 32'h0);
    check_vec("mid_rst_pc", pc_o, 32'h0);
    check_vec("mid_rst_valid", {31'h0, instr_valid_o}, 32'h0);
    rst_i         = 1'b0;
    imem_if.ack   = 1'b1;
    imem_if.rdata = 32'hDEAD_BEEF;
    @(negedge clk_i);
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'h0;
    check_vec("ack_ignored_valid", {31'h0, instr_valid_o}, 32'h0);
    check_vec("ack_ignored_instr", instr_o, 32'h0);
    fetch_one(32'h0000_0000, 32'h0BAD_F00D, 0);

    check_vec("sb_empty", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
